// File: rtl/signed_unit_arbiter.sv
// Round-robin arbiter for two requesters sharing one signed 4-bit unit.
// Optional WAIT-state watchdog is enabled by defining SIGNED_ARB_TIMEOUT_EN.
module signed_unit_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       str,
    input  logic [3:0] unit_dout,
    input  logic       unit_flag,
    output logic [3:0] res,
    output logic       res_valid,
    output logic       res_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t     state_reg;
    logic       owner_reg;
    logic       last_reg;
    logic       gnt0_reg;
    logic       gnt1_reg;
    logic       str_reg;
    logic [3:0] res_reg;
    logic       res_valid_reg;
    logic       res_id_reg;
    logic       busy_reg;
    logic       pick;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    // With both requesting, the one not served last wins; a lone request wins outright.
    assign pick = (req0 && req1) ? ~last_reg : req1;

`ifdef SIGNED_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic       timeout_reg;
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            str_reg       <= 1'b0;
            res_reg       <= 4'b0000;
            res_valid_reg <= 1'b0;
            res_id_reg    <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef SIGNED_ARB_TIMEOUT_EN
            wait_cnt_reg  <= 8'd0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            str_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
`ifdef SIGNED_ARB_TIMEOUT_EN
            timeout_reg   <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        owner_reg <= pick;
                        last_reg  <= pick;
                        gnt0_reg  <= ~pick;
                        gnt1_reg  <= pick;
                        str_reg   <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
`ifdef SIGNED_ARB_TIMEOUT_EN
                    wait_cnt_reg <= 8'd0;
`endif
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A flag in the expiry cycle still counts as a normal result.
                    if (unit_flag) begin
                        res_reg       <= unit_dout;
                        res_id_reg    <= owner_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
`ifdef SIGNED_ARB_TIMEOUT_EN
                    else if (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
                        res_reg       <= 4'b1000;
                        res_id_reg    <= owner_reg;
                        res_valid_reg <= 1'b1;
                        timeout_reg   <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_reg;
    assign gnt1      = gnt1_reg;
    assign str       = str_reg;
    assign res       = res_reg;
    assign res_valid = res_valid_reg;
    assign res_id    = res_id_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_signed_unit_arbiter.sv
// Directed vector bench for signed_unit_arbiter; inputs and outputs are handled
// on the falling edge, so each row observes the state after one rising edge.
module tb_signed_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       gnt0;
    logic       gnt1;
    logic       str;
    logic [3:0] unit_dout = 4'd0;
    logic       unit_flag = 1'b0;
    logic [3:0] res;
    logic       res_valid;
    logic       res_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_unit_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .str(str),
        .unit_dout(unit_dout), .unit_flag(unit_flag),
        .res(res), .res_valid(res_valid), .res_id(res_id),
        .busy(busy), .timeout(timeout)
    );

    typedef struct {
        logic       rst;
        logic       req0;
        logic       req1;
        logic       flag;
        logic [3:0] dout;
        logic       busy;
        logic       str;
        logic       gnt0;
        logic       gnt1;
        logic       rv;
        logic [3:0] res;
        logic       res_id;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic q0, input logic q1, input logic fl,
                       input logic [3:0] d, input logic b, input logic s, input logic g0,
                       input logic g1, input logic v, input logic [3:0] rs, input logic id);
        vec_t v_row;
        v_row = '{r, q0, q1, fl, d, b, s, g0, g1, v, rs, id, 1'b0};
        vecs.push_back(v_row);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic q1, input logic fl,
                         input logic [3:0] d);
        rst = r; req0 = q0; req1 = q1; unit_flag = fl; unit_dout = d;
        @(negedge clk);
    endtask

    initial begin
        //   rst q0 q1 fl dout   busy str g0 g1 rv res    id
        add(1, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'h0, 0); // reset
        add(0, 1, 0, 0, 4'h0,   1, 1, 1, 0, 0, 4'h0, 0); // single job
        add(0, 0, 0, 1, 4'h5,   1, 0, 0, 0, 0, 4'h0, 0); // flag in START ignored
        add(0, 0, 0, 1, 4'hD,   1, 0, 0, 0, 1, 4'hD, 0);
        add(0, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'hD, 0);
        add(1, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'h0, 0); // contention from reset
        add(0, 1, 1, 0, 4'h0,   1, 1, 1, 0, 0, 4'h0, 0);
        add(0, 1, 1, 0, 4'h0,   1, 0, 0, 0, 0, 4'h0, 0);
        add(0, 1, 1, 1, 4'h8,   1, 0, 0, 0, 1, 4'h8, 0); // -8 passes through
        add(0, 1, 1, 0, 4'h0,   0, 0, 0, 0, 0, 4'h8, 0);
        add(0, 1, 1, 0, 4'h0,   1, 1, 0, 1, 0, 4'h8, 0);
        add(0, 1, 1, 0, 4'h0,   1, 0, 0, 0, 0, 4'h8, 0);
        add(0, 1, 1, 1, 4'h7,   1, 0, 0, 0, 1, 4'h7, 1);
        add(0, 1, 1, 0, 4'h0,   0, 0, 0, 0, 0, 4'h7, 1);
        add(0, 1, 1, 0, 4'h0,   1, 1, 1, 0, 0, 4'h7, 1);
        add(0, 1, 1, 0, 4'h0,   1, 0, 0, 0, 0, 4'h7, 1);
        add(0, 0, 0, 1, 4'h3,   1, 0, 0, 0, 1, 4'h3, 0);
        add(0, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'h3, 0);
        add(0, 0, 0, 1, 4'h6,   0, 0, 0, 0, 0, 4'h3, 0); // flag in IDLE ignored
        add(0, 0, 1, 1, 4'h6,   1, 1, 0, 1, 0, 4'h3, 0);
        add(0, 0, 0, 0, 4'h0,   1, 0, 0, 0, 0, 4'h3, 0);
        add(0, 0, 0, 0, 4'h0,   1, 0, 0, 0, 0, 4'h3, 0);
        add(0, 0, 0, 1, 4'hF,   1, 0, 0, 0, 1, 4'hF, 1);
        add(0, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'hF, 1);
        add(0, 1, 0, 0, 4'h0,   1, 1, 1, 0, 0, 4'hF, 1); // reset in WAIT
        add(0, 0, 0, 0, 4'h0,   1, 0, 0, 0, 0, 4'hF, 1);
        add(1, 0, 0, 1, 4'h5,   0, 0, 0, 0, 0, 4'h0, 0);
        add(0, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'h0, 0);
        add(0, 0, 1, 0, 4'h0,   1, 1, 0, 1, 0, 4'h0, 0);
        add(0, 0, 0, 0, 4'h0,   1, 0, 0, 0, 0, 4'h0, 0);
        add(0, 0, 0, 1, 4'hA,   1, 0, 0, 0, 1, 4'hA, 1);
        add(0, 0, 0, 0, 4'h0,   0, 0, 0, 0, 0, 4'hA, 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req0, vecs[i].req1, vecs[i].flag, vecs[i].dout);
            check($sformatf("row%0d.busy", i), {3'b0, busy}, {3'b0, vecs[i].busy});
            check($sformatf("row%0d.str", i), {3'b0, str}, {3'b0, vecs[i].str});
            check($sformatf("row%0d.gnt0", i), {3'b0, gnt0}, {3'b0, vecs[i].gnt0});
            check($sformatf("row%0d.gnt1", i), {3'b0, gnt1}, {3'b0, vecs[i].gnt1});
            check($sformatf("row%0d.res_valid", i), {3'b0, res_valid}, {3'b0, vecs[i].rv});
            check($sformatf("row%0d.res", i), res, vecs[i].res);
            check($sformatf("row%0d.res_id", i), {3'b0, res_id}, {3'b0, vecs[i].res_id});
            check($sformatf("row%0d.timeout", i), {3'b0, timeout}, {3'b0, vecs[i].tmo});
            $display("row %0d: busy=%b str=%b gnt=%b%b res_valid=%b res=%h res_id=%b timeout=%b",
                     i, busy, str, gnt1, gnt0, res_valid, res, res_id, timeout);
        end

`ifdef SIGNED_ARB_TIMEOUT_EN
        // Watchdog expiry: four flagless WAIT cycles, then DONE with -8 and timeout.
        drive(0, 1, 0, 0, 4'h0);
        check("wd.start_gnt0", {3'b0, gnt0}, 4'h1);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, 0, 4'h0);
            check($sformatf("wd.wait%0d_no_valid", k), {3'b0, res_valid}, 4'h0);
        end
        drive(0, 0, 0, 0, 4'h0);
        check("wd.expire_valid", {3'b0, res_valid}, 4'h1);
        check("wd.expire_timeout", {3'b0, timeout}, 4'h1);
        check("wd.expire_res", res, 4'h8);
        check("wd.expire_id", {3'b0, res_id}, 4'h0);
        $display("watchdog expiry: res_valid=%b timeout=%b res=%h", res_valid, timeout, res);
        drive(0, 0, 0, 0, 4'h0);
        check("wd.timeout_clears", {3'b0, timeout}, 4'h0);
        // Flag in the expiry cycle wins over the watchdog.
        drive(0, 0, 1, 0, 4'h0);
        check("wd2.start_gnt1", {3'b0, gnt1}, 4'h1);
        for (int k = 1; k <= 4; k++) drive(0, 0, 0, 0, 4'h0);
        drive(0, 0, 0, 1, 4'h2);
        check("wd2.valid", {3'b0, res_valid}, 4'h1);
        check("wd2.timeout", {3'b0, timeout}, 4'h0);
        check("wd2.res", res, 4'h2);
        check("wd2.id", {3'b0, res_id}, 4'h1);
        $display("watchdog race: res_valid=%b timeout=%b res=%h", res_valid, timeout, res);
`else
        // No watchdog: a flagless job never completes.
        begin
            int seen = 0;
            drive(0, 1, 0, 0, 4'h0);
            check("nowd.start_str", {3'b0, str}, 4'h1);
            for (int k = 0; k < 1000; k++) begin
                drive(0, 0, 0, 0, 4'h0);
                if (res_valid || timeout) seen++;
            end
            check("nowd.no_exit", 4'(seen), 4'h0);
            check("nowd.still_busy", {3'b0, busy}, 4'h1);
            $display("no watchdog: exits=%0d busy=%b after 1000 cycles", seen, busy);
        end
`endif
        drive(1, 0, 0, 0, 4'h0);
        check("final_reset_busy", {3'b0, busy}, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_unit_arbiter.md
SIGNED_UNIT_ARBITER -- requirements
Module: signed_unit_arbiter

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, SHALL set the WAIT-state watchdog limit in clk cycles (range 2..255).
REQ-003 Port `clk`, input, 1 bit: rising-edge clock.
REQ-004 Port `rst`, input, 1 bit: synchronous active-high reset.
REQ-005 Port `req0`, input, 1 bit: requester 0 job request, level, held until its grant.
REQ-006 Port `req1`, input, 1 bit: requester 1 job request, level, held until its grant.
REQ-007 Port `gnt0`, output, 1 bit: one-cycle pulse, requester 0 job accepted.
REQ-008 Port `gnt1`, output, 1 bit: one-cycle pulse, requester 1 job accepted.
REQ-009 Port `str`, output, 1 bit: one-cycle start pulse to the shared signed unit.
REQ-010 Port `unit_dout`, input, 4 bits: two's-complement result from the shared unit.
REQ-011 Port `unit_flag`, input, 1 bit: shared-unit result valid.
REQ-012 Port `res`, output, 4 bits: captured two's-complement result.
REQ-013 Port `res_valid`, output, 1 bit: one-cycle pulse, `res`/`res_id`/`timeout` valid.
REQ-014 Port `res_id`, output, 1 bit: requester owning `res`.
REQ-015 Port `busy`, output, 1 bit: high in every state except IDLE.
REQ-016 Port `timeout`, output, 1 bit: qualifies `res_valid`, job aborted by watchdog.

Function
REQ-017 The FSM SHALL have states IDLE, START, WAIT and DONE, all outputs registered.
REQ-018 IDLE with any request SHALL go to START on the next edge, latching the selected requester as owner.
REQ-019 Arbitration SHALL be round-robin: if both request, the requester not served last SHALL win; after reset requester 0 SHALL win first.
REQ-020 In START, for exactly one cycle: `str`=1 and the owner's `gnt` SHALL be 1; next state WAIT.
REQ-021 `unit_flag` SHALL be ignored outside WAIT, including the START cycle.
REQ-022 In WAIT, `unit_flag`=1 SHALL capture `unit_dout` into `res` and go to DONE.
REQ-023 In DONE, for exactly one cycle: `res_valid`=1 and `res_id`=owner; next state IDLE.
REQ-024 Minimum job latency, from request sampled in IDLE to `res_valid`, SHALL be 3 cycles when `unit_flag` arrives in the first WAIT cycle.
REQ-025 `res` and `res_id` SHALL hold their value until the next DONE.
REQ-026 A request dropped before its grant SHALL be discarded without error; requests seen outside IDLE SHALL be serviced on the next IDLE.
REQ-027 `res` SHALL be passed bit-exact; 4'b1000 (-8) is a legal result.

Reset
REQ-028 Reset SHALL force IDLE, the last-served pointer to requester 1, and all outputs to 0.
REQ-029 Reset asserted mid-job SHALL abort the job: no `res_valid`, and no `str` in the cycle after reset.

Configuration
REQ-030 With SIGNED_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; after TIMEOUT_CYCLES WAIT cycles without `unit_flag`, the block SHALL enter DONE with `res`=4'b1000 and `timeout`=1.
REQ-031 With SIGNED_ARB_TIMEOUT_EN defined, `unit_flag` arriving in the same cycle as expiry SHALL win: normal capture, `timeout`=0.
REQ-032 Without SIGNED_ARB_TIMEOUT_EN, the block SHALL have no counter, WAIT SHALL wait indefinitely, and `timeout` SHALL be tied to 0.

Verification
REQ-033 Single job: req0 pulse held; `unit_flag`=1 with `unit_dout`=4'b1101 one cycle after `str` -> `gnt0` and `str` in cycle 1, then `res_valid` with `res`=4'b1101 (-3) and `res_id`=0.
REQ-034 Contention: req0 and req1 held together for 3 jobs -> grant order 0, 1, 0, and `res_id` matches each grant.
REQ-035 Flag outside WAIT: `unit_flag`=1 during START and IDLE -> no `res_valid` until a flag arrives in WAIT.
REQ-036 Watchdog (macro on, TIMEOUT_CYCLES=4): no flag -> `res_valid`=1, `timeout`=1, `res`=4'b1000; flag on the 4th WAIT cycle -> `timeout`=0; macro off -> no exit after 1000 cycles.
REQ-037 Reset in WAIT: `rst` for 1 cycle -> `busy`=0, no `res_valid`; next req1 alone -> `gnt1` accepted normally.
